// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: grants the shared system bus to one master per
// transaction, inserts a one-cycle turnaround gap between owners, and aborts
// a transaction whose slave never asserts ready.
module bus_arbiter #(
  parameter int N       = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    request,
  input  logic            ready,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] owner,
  output logic            busy,
  output logic            bus_error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [7:0]      CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] ID_LAST  = ID_W'(N - 1);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic [2*N-1:0]    req_dbl;
  logic [N-1:0]      scan;
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   win;
  logic              found;
  logic              own_req;
  logic [ID_W-1:0]   next_ptr;

  // Round-robin search: rotate request so bit 0 is master ptr, then take the
  // first set bit while tracking its wrapped master index.
  always_comb begin
    req_dbl = {request, request} >> ptr_q;
    scan    = req_dbl[N-1:0];
    cand    = ptr_q;
    win     = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && scan[0]) begin
        found = 1'b1;
        win   = cand;
      end
      scan = scan >> 1;
      cand = (cand == ID_LAST) ? '0 : cand + ID_W'(1);
    end
  end

  // Owner's own request bit and the pointer value after its release.
  always_comb begin
    own_req  = |(request & (N'(1) << owner_q));
    next_ptr = (owner_q == ID_LAST) ? '0 : owner_q + ID_W'(1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    owner_d = owner_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_BUSY: begin
        if (ready || !own_req || cnt_q == CNT_LAST) begin
          state_d = S_GAP;
          grant_d = '0;
          ptr_d   = next_ptr;
          err_d   = !ready && own_req && (cnt_q == CNT_LAST);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        if (found) begin
          state_d = S_BUSY;
          grant_d = N'(1) << win;
          owner_d = win;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
    endcase
    busy_d = |grant_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign bus_error = err_q;

endmodule
